pipeline_idc_queue: RTL

- Parametrised successor to the single-register decode-control stage.
- Sits between the IF-side decoder (imm/ctrl outputs) and the ID/EX boundary.
- Buffers up to DEPTH decoded instructions in order, with a valid/ready handshake on both sides instead of a global stall.
- Supports pipeline flush with drop accounting; an empty queue presents a zeroed bubble downstream.

---
 rtl/pipeline_idc_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipeline_idc_queue.sv
// In-order queue of decoded instructions between the decoder and the ID/EX boundary.
// Valid/ready on both sides, flush with saturating drop accounting, zeroed bubble when empty.
module pipeline_idc_queue #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 24,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_imm,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_imm,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  logic [4:0]        rd_q   [DEPTH];
  logic [4:0]        rs1_q  [DEPTH];
  logic [4:0]        rs2_q  [DEPTH];
  logic [XLEN-1:0]   pc_q   [DEPTH];
  logic [XLEN-1:0]   imm_q  [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [SUM_W-1:0] dropSum;
  logic             push, pop;
  logic             unusedInstBits;

  assign unusedInstBits = ^{in_inst[31:25], in_inst[14:12], in_inst[6:0]};

  // Handshake qualifiers depend only on registered occupancy.
  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign dropSum   = {1'b0, drop_q} + SUM_W'(count_q);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    drop_d  = drop_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      drop_d  = dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  // Entry storage; a push in a flush cycle is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        rs1_q[i]  <= '0;
        rs2_q[i]  <= '0;
        pc_q[i]   <= '0;
        imm_q[i]  <= '0;
        ctrl_q[i] <= '0;
      end
    end else if (push && !flush) begin
      rd_q[tail_q]   <= in_inst[11:7];
      rs1_q[tail_q]  <= in_inst[19:15];
      rs2_q[tail_q]  <= in_inst[24:20];
      pc_q[tail_q]   <= in_pc;
      imm_q[tail_q]  <= in_imm;
      ctrl_q[tail_q] <= in_ctrl;
    end
  end

  // Empty queue drives an all-zero bubble so control bits read as inactive.
  assign out_rd   = out_valid ? rd_q[head_q]   : '0;
  assign out_rs1  = out_valid ? rs1_q[head_q]  : '0;
  assign out_rs2  = out_valid ? rs2_q[head_q]  : '0;
  assign out_pc   = out_valid ? pc_q[head_q]   : '0;
  assign out_imm  = out_valid ? imm_q[head_q]  : '0;
  assign out_ctrl = out_valid ? ctrl_q[head_q] : '0;
  assign count    = count_q;
  assign drop_cnt = drop_q;

endmodule
